// File: rtl/regfile_pkg.sv
// Shared register-file widths, the hard-wired zero register and helpers used by
// the writeback scheduler and its arbiter.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // True for the architectural zero register, whose writes are discarded.
  function automatic logic is_zero_reg(input reg_addr_t addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer upwards with
// wrap-around; the pointer moves past the winner only when advance is high.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic [PW-1:0] ptr
);

  logic found;

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register file write port between writeback sources and tracks
// pending destination registers so decode can stall on RAW/WAW hazards.
module regfile_wb_scheduler #(
  parameter int NUM_SRC  = 3,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_dest,
  output logic                      issue_ready,
  input  logic [ADDR_W-1:0]         rd_addr1,
  input  logic [ADDR_W-1:0]         rd_addr2,
  output logic                      stall,
  output logic [NUM_REGS-1:0]       busy
);

  import regfile_pkg::*;

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  // Handshake: source i transfers in a cycle where src_valid[i] & src_ready[i];
  // a source holds valid/addr/data stable until granted, and ready never
  // depends on that source's own data.
  logic [NUM_SRC-1:0]  gnt;
  logic [PW-1:0]       gnt_idx;
  logic [PW-1:0]       rr_ptr;
  logic                wb_fire;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_nonzero;
  logic                issue_fire;
  logic [NUM_REGS-1:0] busy_next;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (src_valid),
    .advance (wb_fire),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .ptr     (rr_ptr)
  );

  assign src_ready   = gnt;
  assign wb_fire     = |(src_valid & gnt);
  assign sel_addr    = src_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_data    = src_data[int'(gnt_idx)*DATA_W +: DATA_W];
  assign sel_nonzero = sel_addr != ZERO_ADDR;

  assign issue_ready = !busy[issue_dest] || (issue_dest == ZERO_ADDR);
  assign issue_fire  = issue_valid && issue_ready && (issue_dest != ZERO_ADDR);

  assign stall = (busy[rd_addr1] && (rd_addr1 != ZERO_ADDR)) ||
                 (busy[rd_addr2] && (rd_addr2 != ZERO_ADDR));

  // Clear first, then set, so a new issue to the register being written wins.
  always_comb begin
    busy_next = busy;
    if (wb_fire && sel_nonzero) busy_next[sel_addr] = 1'b0;
    if (issue_fire) busy_next[issue_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy     <= '0;
    end else begin
      rf_we <= wb_fire && sel_nonzero;
      if (wb_fire && sel_nonzero) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed vector table, hand sequences for
// zero-register and reset corners, then random traffic against a reference model.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [14:0] src_addr;
  logic [95:0] src_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic        issue_ready;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        stall;
  logic [31:0] busy;

  regfile_wb_scheduler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_addr    (src_addr),
    .src_data    (src_data),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .issue_ready (issue_ready),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .stall       (stall),
    .busy        (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_busy;
  int          m_ptr;
  int          m_g;
  logic        m_hs;
  logic [36:0] exp_q[$];

  typedef struct {
    logic [2:0]  v;
    logic [4:0]  a0, a1, a2;
    logic        iv;
    logic [4:0]  idest;
    logic [4:0]  rd1;
    logic [2:0]  e_ready;
    logic        e_stall;
    logic        e_iready;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dat(input int s, input logic [4:0] a);
    return 32'hD000_0000 | (s << 8) | 32'(a);
  endfunction

  function automatic int model_grant(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++) begin
      if (v[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  // One clock: check combinational outputs against the model, advance the
  // model, then check registered outputs just after the edge.
  task automatic cycle();
    int          g;
    logic [4:0]  a;
    logic [31:0] d;
    logic        e_we;
    logic        accept;
    logic [36:0] item;
    #3;
    g = model_grant(src_valid, m_ptr);
    if (reset_n) begin
      chk("src_ready", 64'(src_ready), (g < 0) ? 64'd0 : (64'd1 << g));
      chk("issue_ready", 64'(issue_ready), 64'(!m_busy[issue_dest] || issue_dest == 5'd0));
      chk("stall", 64'(stall),
          64'((m_busy[rd_addr1] && rd_addr1 != 5'd0) || (m_busy[rd_addr2] && rd_addr2 != 5'd0)));
    end
    e_we = 1'b0;
    m_hs = 1'b0;
    m_g  = g;
    if (!reset_n) begin
      m_busy = '0;
      m_ptr  = 0;
      exp_q.delete();
    end else begin
      accept = issue_valid && issue_dest != 5'd0 && !m_busy[issue_dest];
      if (g >= 0) begin
        m_hs  = 1'b1;
        a     = src_addr[g*5 +: 5];
        d     = src_data[g*32 +: 32];
        m_ptr = (g + 1) % 3;
        if (a != 5'd0) begin
          exp_q.push_back({a, d});
          e_we = 1'b1;
          m_busy[a] = 1'b0;
        end
      end
      if (accept) m_busy[issue_dest] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("rf_we", 64'(rf_we), 64'(e_we));
    if (rf_we === 1'b1) begin
      chk("wq_size", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) begin
        item = exp_q.pop_front();
        chk("rf_write", {27'd0, rf_waddr, rf_wdata}, {27'd0, item});
      end
    end
    exp_q.delete();
    chk("busy", 64'(busy), 64'(m_busy));
  endtask

  task automatic drive(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2, input logic iv, input logic [4:0] idest,
                       input logic [4:0] rd1, input logic [4:0] rd2);
    src_valid   = v;
    src_addr    = {a2, a1, a0};
    src_data    = {dat(2, a2), dat(1, a1), dat(0, a0)};
    issue_valid = iv;
    issue_dest  = idest;
    rd_addr1    = rd1;
    rd_addr2    = rd2;
  endtask

  task automatic run_row(input int i);
    vec_t r;
    int   gs;
    logic [4:0] ga;
    r = vecs[i];
    drive(r.v, r.a0, r.a1, r.a2, r.iv, r.idest, r.rd1, 5'd0);
    #2;
    chk($sformatf("row%0d_ready", i), 64'(src_ready), 64'(r.e_ready));
    chk($sformatf("row%0d_stall", i), 64'(stall), 64'(r.e_stall));
    chk($sformatf("row%0d_iready", i), 64'(issue_ready), 64'(r.e_iready));
    cycle();
    chk($sformatf("row%0d_we", i), 64'(rf_we), 64'(r.e_we));
    chk($sformatf("row%0d_busy", i), 64'(busy), 64'(r.e_busy));
    if (r.e_we) begin
      gs = 0;
      for (int s = 0; s < 3; s++) if (r.e_ready[s]) gs = s;
      ga = (gs == 0) ? r.a0 : (gs == 1) ? r.a1 : r.a2;
      chk($sformatf("row%0d_waddr", i), 64'(rf_waddr), 64'(r.e_waddr));
      chk($sformatf("row%0d_wdata", i), 64'(rf_wdata), 64'(dat(gs, ga)));
    end
  endtask

  logic       pv[3];
  logic [4:0] pa[3];
  logic [31:0] pd[3];

  initial begin
    //          v      a0 a1 a2 iv idest rd1  ready  st ir we waddr busy
    vecs[0]  = '{3'b000, 0, 0, 0, 0, 0,  0, 3'b000, 0, 1, 0, 0,  32'h0};
    vecs[1]  = '{3'b111, 3, 4, 5, 0, 0,  0, 3'b001, 0, 1, 1, 3,  32'h0};
    vecs[2]  = '{3'b111, 3, 4, 5, 0, 0,  0, 3'b010, 0, 1, 1, 4,  32'h0};
    vecs[3]  = '{3'b111, 3, 4, 5, 0, 0,  0, 3'b100, 0, 1, 1, 5,  32'h0};
    vecs[4]  = '{3'b111, 3, 4, 5, 0, 0,  0, 3'b001, 0, 1, 1, 3,  32'h0};
    vecs[5]  = '{3'b000, 0, 0, 0, 1, 7,  7, 3'b000, 0, 1, 0, 0,  32'h80};
    vecs[6]  = '{3'b000, 0, 0, 0, 0, 7,  7, 3'b000, 1, 0, 0, 0,  32'h80};
    vecs[7]  = '{3'b010, 0, 7, 0, 0, 7,  7, 3'b010, 1, 0, 1, 7,  32'h0};
    vecs[8]  = '{3'b000, 0, 0, 0, 0, 7,  7, 3'b000, 0, 1, 0, 0,  32'h0};
    vecs[9]  = '{3'b000, 0, 0, 0, 1, 9,  0, 3'b000, 0, 1, 0, 0,  32'h200};
    vecs[10] = '{3'b000, 0, 0, 0, 1, 9,  0, 3'b000, 0, 0, 0, 0,  32'h200};
    vecs[11] = '{3'b100, 0, 0, 9, 1, 9,  0, 3'b100, 0, 0, 1, 9,  32'h0};
    vecs[12] = '{3'b000, 0, 0, 0, 1, 9,  0, 3'b000, 0, 1, 0, 0,  32'h200};
    vecs[13] = '{3'b001, 10, 0, 0, 1, 10, 0, 3'b001, 0, 1, 1, 10, 32'h600};
    vecs[14] = '{3'b010, 0, 9, 0, 0, 0,  0, 3'b010, 0, 1, 1, 9,  32'h400};

    m_busy  = '0;
    m_ptr   = 0;
    reset_n = 1'b0;
    drive(3'b000, 0, 0, 0, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle();
    cycle();
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) run_row(i);

    // write to the zero register: handshake completes, no write, no stall
    drive(3'b001, 0, 0, 0, 1'b0, 5'd0, 5'd0, 5'd0);
    src_data[31:0] = 32'hFFFF_FFFF;
    #2;
    chk("zero_ready", 64'(src_ready), 64'b001);
    chk("zero_stall", 64'(stall), 64'd0);
    cycle();
    chk("zero_we", 64'(rf_we), 64'd0);

    // build busy = 0x0F00 (r10 already pending), then reset mid-traffic
    drive(3'b000, 0, 0, 0, 1'b1, 5'd8, 5'd0, 5'd0);
    cycle();
    issue_dest = 5'd9;
    cycle();
    issue_dest = 5'd11;
    cycle();
    chk("busy_f00", 64'(busy), 64'h0F00);
    drive(3'b111, 12, 13, 14, 1'b0, 5'd0, 5'd0, 5'd0);
    reset_n = 1'b0;
    cycle();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_we", 64'(rf_we), 64'd0);
    reset_n = 1'b1;
    #2;
    chk("rst_ptr_gnt", 64'(src_ready), 64'b001);
    cycle();
    chk("rst_first_waddr", 64'(rf_waddr), 64'd12);

    // random traffic; sources hold their request until granted
    for (int s = 0; s < 3; s++) pv[s] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int s = 0; s < 3; s++) begin
        if (!pv[s] && $urandom_range(0, 1) == 1) begin
          pv[s] = 1'b1;
          pa[s] = 5'($urandom_range(0, 15));
          pd[s] = $urandom;
        end
      end
      reset_n     = !(c >= 300 && c < 302);
      src_valid   = {pv[2], pv[1], pv[0]};
      src_addr    = {pa[2], pa[1], pa[0]};
      src_data    = {pd[2], pd[1], pd[0]};
      issue_valid = 1'($urandom_range(0, 1));
      issue_dest  = 5'($urandom_range(0, 15));
      rd_addr1    = 5'($urandom_range(0, 15));
      rd_addr2    = 5'($urandom_range(0, 15));
      cycle();
      if (m_hs && m_g >= 0) pv[m_g] = 1'b0;
    end
    reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
